// File: rtl/stream_merge_2to1.sv
// stream_merge_2to1: packet-aware round-robin 2:1 valid/ready merger with a registered output stage.
// The grant is locked for a whole packet so beats from the two inputs never interleave.
module stream_merge_2to1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              out_sel_q, out_sel_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              load, sel, req, xfer, xfer_last;

    always_comb begin
        load        = !out_valid_q || out_ready;
        // a locked input keeps the grant; in IDLE a lone requester wins, otherwise prio decides
        sel         = state_q == LOCK1 || (state_q == IDLE && in1_valid && (!in0_valid || prio_q));
        req         = state_q != IDLE || in0_valid || in1_valid;
        in0_ready   = rst_n && load && req && !sel;
        in1_ready   = rst_n && load && req && sel;
        xfer        = sel ? in1_valid && in1_ready : in0_valid && in0_ready;
        xfer_last   = sel ? in1_last : in0_last;
        state_d     = state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            state_d     = xfer_last ? IDLE : (sel ? LOCK1 : LOCK0);
            prio_d      = xfer_last ? !sel : prio_q;
            out_valid_d = 1'b1;
            out_data_d  = sel ? in1_data : in0_data;
            out_last_d  = xfer_last;
            out_sel_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign busy      = state_q != IDLE;
endmodule

// File: doc/stream_merge_2to1.md
Name: stream_merge_2to1

Overview:
- Two-input, packet-aware round-robin merger that sits directly upstream of the 2:1 select stage.
- Arbitrates between two valid/ready streams and emits one registered stream.
- Produces out_sel with mux polarity: 0 = input 0 (d0), 1 = input 1 (d1).
- Holds a grant for the whole packet (until the beat with last=1), so packets from the two inputs never interleave.

Parameters:
DATA_W, 8, width of data on each input and on the output.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in0_valid  input  1  input 0 beat available
in0_ready  output  1  input 0 beat accepted this cycle
in0_data  input  DATA_W  input 0 payload
in0_last  input  1  input 0 final beat of packet
in1_valid  input  1  input 1 beat available
in1_ready  output  1  input 1 beat accepted this cycle
in1_data  input  DATA_W  input 1 payload
in1_last  input  1  input 1 final beat of packet
out_valid  output  1  output beat available
out_ready  input  1  downstream accepts output beat
out_data  output  DATA_W  registered payload
out_last  output  1  registered last flag
out_sel  output  1  source of the current output beat (0 = in0, 1 = in1)
busy  output  1  high while a grant is locked mid-packet

Behaviour:
- Reset (rst_n=0, async):
  - out_valid=0, out_data=0, out_last=0, out_sel=0, busy=0.
  - state=IDLE, priority pointer prio=0.
  - in0_ready=in1_ready=0 while rst_n=0.
- load = !out_valid || out_ready. The output register may take a new beat this cycle.
- Transfer on input x when inx_valid && inx_ready. At most one input transfers per cycle.
- inx_ready is combinational from load, state, prio and the valids. Upstream valid must never depend on ready.
- State IDLE:
  - Grant when load=1: only one valid → grant it; both valid → grant input prio; none → no grant.
  - granted_ready = load; the other ready = 0.
  - Transfer with last=1 → stay IDLE, prio = other input.
  - Transfer with last=0 → go to LOCKx, where x is the granted input.
- State LOCK0 / LOCK1:
  - in_x_ready = load; the other ready = 0 regardless of its valid.
  - Transfer with last=1 → IDLE, prio = other input.
  - Transfer with last=0 → stay.
  - No transfer → stay, with no timeout.
- busy = (state != IDLE).
- Output register:
  - On a transfer, out_data, out_last and out_sel are loaded from the granted input next edge, and out_valid=1.
  - If out_ready=1 and there is no transfer, out_valid clears.
  - If out_valid=1 and out_ready=0, all out_* hold stable.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle with out_ready held high.
- Fairness: single-beat packets alternate when both inputs are continuously valid. With one input idle, the other is served every cycle; prio never blocks a lone requester.
- Simultaneous arrival in the same cycle as a packet end: the new grant applies from the next cycle; a packet end and a new grant never fall in one cycle.
- Reset mid-packet: the lock is abandoned, the partial packet is dropped with no recovery, and the first grant after reset goes to in0 if both are valid.

Test Plan:
1. Reset: hold rst_n=0 with in0_valid=in1_valid=1 → in0_ready=in1_ready=0, out_valid=0, out_sel=0. Release → first accepted beat comes from in0.
2. Alternation: both valid, last=1 every beat, in0_data=A0,A1,..., in1_data=B0,B1,..., out_ready=1 → out_data A0,B0,A1,B1 on consecutive cycles, out_sel 0,1,0,1, first out_valid one cycle after release.
3. Packet lock: in0 sends a 3-beat packet (11,22,33, last on 33) while in1 (44, last=1) is valid throughout → output 11,22,33 with out_sel=0, then 44 with out_sel=1. in1_ready=0 and busy=1 while in0 is mid-packet.
4. Backpressure: out_valid=1 holding 5A, drive out_ready=0 for 4 cycles → out_data stays 5A, both readies=0. Drive out_ready=1 → stream resumes with no lost or duplicated beat.
5. Reset mid-packet: in1 sends 2 beats with last=0, then rst_n pulses low → busy=0, out_valid=0. Both valid afterwards → in0 granted first.
6. Lone requester: only in1_valid=1 for 8 single-beat packets, out_ready=1 → in1_ready=1 every cycle, 8 beats out back-to-back, out_sel=1 throughout.
